jtopl_eg_sched: RTL and testbench
=================================

# jtopl_eg_sched

Envelope-step scheduler for the OPL envelope generator. It runs the 18-slot operator sequence and drives `zero` to the envelope counter once per frame. For each slot, it combines that slot's 6-bit effective rate with the current counter value and decides whether the envelope advances, and by how much. It sits between the shared envelope counter and the per-operator attenuation update logic.

## Interface
Parameters:
- `SLOTS`, 18: operator slots per frame (fixed by OPL2 timing; only 18 is supported).

Ports:
- `clk`  in  1: clock.
- `rst`  in  1: reset, asynchronous, active-high.
- `cen`  in  1: clock enable; one slot per `cen` cycle.
- `rate`  in  6: effective rate of the current slot (`rate[5:2]`=rate_hi, `rate[1:0]`=rate_lo); valid on `cen` cycles.
- `eg_cnt`  in  15: envelope counter value, stable for a whole frame.
- `test`  in  1: force-step test input (only with `JTOPL_EG_TEST_EN`).
- `slot`  out  5: current slot index, 0..17.
- `zero`  out  1: high while `slot`==17; tells the counter to increment.
- `step`  out  1: registered; the envelope advances this slot.
- `inc`  out  3: registered; attenuation increment, 0..4.
- `slot_q`  out  5: registered; slot tag for `step`/`inc`.

## Operation
- Slot counter: on `cen`, `slot` goes 0→1→…→17→0. It wraps only at 17. Values 18..31 never occur; if one is reached, the next `cen` loads 0.
- `zero` is combinational from `slot`==17 and is high for the full slot-17 interval. The counter increments on the `cen` edge that ends slot 17, so `eg_cnt` holds one value across slots 0..17 of every frame.
- Step decision, evaluated on each `cen` from `rate` and `eg_cnt`:
  - rate_hi==0: `step`=0, `inc`=0.
  - rate_hi 1..12:
    - sh = 13−rate_hi (1..12); idx = `eg_cnt[sh+2:sh]`; p = PATTERN[rate_lo][idx].
    - `step` = (`eg_cnt[sh-1:0]`==0) & p; `inc` = `step`.
  - rate_hi 13: `step`=1, `inc` = p ? 2 : 1, where idx = `eg_cnt[2:0]`.
  - rate_hi 14: `step`=1, `inc` = p ? 4 : 2, where idx = `eg_cnt[2:0]`.
  - rate_hi 15: `step`=1, `inc`=4.
- PATTERN (bit i is entry i): rl0=8'hAA, rl1=8'hBA, rl2=8'hEE, rl3=8'hFE.
- All bit indices stay within 0..14. No overflow is possible, and `inc` never exceeds 4.
- With `cen` low, every register holds.

## Timing
- Reset values: `slot`=0, `zero`=0, `step`=0, `inc`=0, `slot_q`=0.
- Latency: `step`/`inc`/`slot_q` update on the same `cen` edge that advances `slot`. They therefore describe the slot that just ended: `slot_q` = previous `slot`.
- Frame length is 18 `cen` pulses, with exactly one `zero` slot per frame.
- Reset mid-frame: everything returns to the reset values at once. The first `cen` after release produces the result for slot 0.
- No handshake. Consumers sample on `cen`, qualified by `slot_q`.

## Configuration
- `JTOPL_EG_TEST_EN` defined: the `test` port exists. When `test`=1, `step`=1 and `inc`=4 for every slot, regardless of `rate` (OPL test register behaviour).
- Not defined: the `test` port is absent and the normal schedule always applies.

## Structure
- Shared package `jtopl_pkg`: `SLOTS`=18, `LAST_SLOT`=17, and the PATTERN constant array (4×8 bits).
- One sub-module, `jtopl_eg_step`: the combinational rate/counter → step/inc decision. The top level holds the slot counter, the `zero` decode and the output registers.

## Test plan
- Reset, then 40 `cen` pulses → `slot` sequence 0..17,0..17,0..3; `zero` high exactly when `slot`==17; `slot_q` lags `slot` by one.
- `rate`=6'd4 (rate_hi 1, rl0), sweep `eg_cnt` 0..32767 → `step` only when `eg_cnt[11:0]`==0 and `eg_cnt[13:12]`∈{1,3} with `eg_cnt[14]` any; `inc`=1 on those slots.
- `rate`=6'd52 (rate_hi 13, rl0), `eg_cnt`=1 → `step`=1, `inc`=2; `eg_cnt`=2 → `inc`=1.
- `rate`=6'd63 → `inc`=4 every slot; `rate`=6'd3 → `step`=0 every slot.
- Assert `rst` with `slot`=9 mid-frame → all outputs 0 immediately; after release the first `cen` gives `slot`=1, `slot_q`=0.
- With `JTOPL_EG_TEST_EN`: `test`=1, `rate`=0 → `step`=1, `inc`=4 on all 18 slots.

Source files
------------

// File: rtl/jtopl_pkg.sv
// Shared OPL constants: frame geometry and the envelope step patterns.
package jtopl_pkg;

    localparam int         SLOTS     = 18;
    localparam logic [4:0] LAST_SLOT = 5'd17;

    // Step pattern per rate_lo; bit i of entry rl is PATTERN[rl][i]
    localparam logic [3:0][7:0] PATTERN = {8'hFE, 8'hEE, 8'hBA, 8'hAA};

    // Pattern lookup for a given rate_lo and 3-bit counter index
    function automatic logic pattern_bit(input logic [1:0] rl, input logic [2:0] idx);
        logic [7:0] row;
        row = PATTERN[rl];
        return row[idx];
    endfunction

endpackage

// File: rtl/jtopl_eg_step.sv
// Combinational step/increment decision from a slot's effective rate and the
// shared envelope counter. test_mode forces the maximum step (OPL test register).
module jtopl_eg_step
    import jtopl_pkg::*;
(
    input  logic [5:0]  rate,
    input  logic [14:0] eg_cnt,
    input  logic        test_mode,
    output logic        step,
    output logic [2:0]  inc
);

    logic [3:0]  rate_hi;
    logic [1:0]  rate_lo;
    logic [3:0]  sh;
    logic [14:0] shifted;
    logic [14:0] mask;
    logic        p;

    assign rate_hi = rate[5:2];
    assign rate_lo = rate[1:0];

    // Rate class decode: slow rates gate on counter low bits, fast rates always step
    always_comb begin
        step    = 1'b0;
        inc     = 3'd0;
        sh      = 4'd0;
        shifted = eg_cnt;
        mask    = 15'd0;
        p       = 1'b0;
        if (test_mode) begin
            step = 1'b1;
            inc  = 3'd4;
        end else if (rate_hi == 4'd0) begin
            step = 1'b0;
            inc  = 3'd0;
        end else if (rate_hi <= 4'd12) begin
            sh      = 4'd13 - rate_hi;
            shifted = eg_cnt >> sh;
            mask    = (15'd1 << sh) - 15'd1;
            p       = pattern_bit(rate_lo, shifted[2:0]);
            step    = ((eg_cnt & mask) == 15'd0) && p;
            inc     = {2'b00, step};
        end else if (rate_hi == 4'd13) begin
            p    = pattern_bit(rate_lo, eg_cnt[2:0]);
            step = 1'b1;
            inc  = p ? 3'd2 : 3'd1;
        end else if (rate_hi == 4'd14) begin
            p    = pattern_bit(rate_lo, eg_cnt[2:0]);
            step = 1'b1;
            inc  = p ? 3'd4 : 3'd2;
        end else begin
            step = 1'b1;
            inc  = 3'd4;
        end
    end

endmodule

// File: rtl/jtopl_eg_sched.sv
// Envelope-step scheduler: walks the 18 operator slots, flags the last slot so
// the envelope counter advances once per frame, and registers the step/inc
// decision tagged with the slot it belongs to.
// Optional feature: define JTOPL_EG_TEST_EN to add the 'test' force-step port.
module jtopl_eg_sched
    import jtopl_pkg::*;
#(
    parameter int SLOTS = jtopl_pkg::SLOTS
)
(
    input  logic        clk,
    input  logic        rst,
    input  logic        cen,
    input  logic [5:0]  rate,
    input  logic [14:0] eg_cnt,
`ifdef JTOPL_EG_TEST_EN
    input  logic        test,
`endif
    output logic [4:0]  slot,
    output logic        zero,
    output logic        step,
    output logic [2:0]  inc,
    output logic [4:0]  slot_q
);

    localparam logic [4:0] LAST = 5'(SLOTS - 1);

    logic [4:0] cnt_q, cnt_d;
    logic [4:0] slot_d;
    logic       step_q, step_d;
    logic [2:0] inc_q, inc_d;
    logic       dec_step;
    logic [2:0] dec_inc;
    logic       test_mode;

`ifdef JTOPL_EG_TEST_EN
    assign test_mode = test;
`else
    assign test_mode = 1'b0;
`endif

    jtopl_eg_step u_step (
        .rate      (rate),
        .eg_cnt    (eg_cnt),
        .test_mode (test_mode),
        .step      (dec_step),
        .inc       (dec_inc)
    );

    assign slot = cnt_q;
    assign zero = (cnt_q == LAST_SLOT);
    assign step = step_q;
    assign inc  = inc_q;

    // Next-state: advance slot (any out-of-range value recovers to 0) and capture the decision
    always_comb begin
        cnt_d  = cnt_q;
        slot_d = slot_q;
        step_d = step_q;
        inc_d  = inc_q;
        if (cen) begin
            cnt_d  = (cnt_q >= LAST) ? 5'd0 : cnt_q + 5'd1;
            slot_d = cnt_q;
            step_d = dec_step;
            inc_d  = dec_inc;
        end
    end

    // State registers with asynchronous reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q  <= 5'd0;
            slot_q <= 5'd0;
            step_q <= 1'b0;
            inc_q  <= 3'd0;
        end else begin
            cnt_q  <= cnt_d;
            slot_q <= slot_d;
            step_q <= step_d;
            inc_q  <= inc_d;
        end
    end

endmodule

// File: tb/tb_jtopl_eg_sched.sv
// Directed self-checking bench for jtopl_eg_sched.
module tb_jtopl_eg_sched;

    logic        clk;
    logic        rst;
    logic        cen;
    logic [5:0]  rate;
    logic [14:0] eg_cnt;
`ifdef JTOPL_EG_TEST_EN
    logic        test;
`endif
    logic [4:0]  slot;
    logic        zero;
    logic        step;
    logic [2:0]  inc;
    logic [4:0]  slot_q;

    int errors = 0;
    int checks = 0;
    int exp_slot = 0;
    int exp_prev = 0;

    jtopl_eg_sched dut (
        .clk    (clk),
        .rst    (rst),
        .cen    (cen),
        .rate   (rate),
        .eg_cnt (eg_cnt),
`ifdef JTOPL_EG_TEST_EN
        .test   (test),
`endif
        .slot   (slot),
        .zero   (zero),
        .step   (step),
        .inc    (inc),
        .slot_q (slot_q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, got, want);
        end
    endtask

    // One cen pulse with the given rate/counter; also advances the slot model
    task automatic applyStimulus(input logic [5:0] r, input logic [14:0] c);
        rate   = r;
        eg_cnt = c;
        cen    = 1'b1;
        @(posedge clk);
        #1;
        cen      = 1'b0;
        exp_prev = exp_slot;
        exp_slot = (exp_slot == 17) ? 0 : exp_slot + 1;
    endtask

    task automatic checkSlot(input string tag);
        checkOutput({tag, "_slot"}, 32'(slot), 32'(exp_slot));
        checkOutput({tag, "_slot_q"}, 32'(slot_q), 32'(exp_prev));
        checkOutput({tag, "_zero"}, 32'(zero), 32'(exp_slot == 17));
    endtask

    task automatic checkStep(input string tag, input logic s, input logic [2:0] i);
        checkOutput({tag, "_step"}, 32'(step), 32'(s));
        checkOutput({tag, "_inc"}, 32'(inc), 32'(i));
    endtask

    initial begin
        logic [14:0] c;
        logic        want;
        logic [4:0]  held_slot;
        cen    = 1'b0;
        rate   = 6'd0;
        eg_cnt = 15'd0;
`ifdef JTOPL_EG_TEST_EN
        test   = 1'b0;
`endif
        rst = 1'b1;
        #1;
        checkOutput("reset_slot", 32'(slot), 32'd0);
        checkOutput("reset_zero", 32'(zero), 32'd0);
        checkOutput("reset_step", 32'(step), 32'd0);
        checkOutput("reset_inc", 32'(inc), 32'd0);
        checkOutput("reset_slot_q", 32'(slot_q), 32'd0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Slot sequence over 40 pulses
        for (int n = 0; n < 40; n++) begin
            applyStimulus(6'd0, 15'd0);
            checkSlot("seq");
            checkStep("seq", 1'b0, 3'd0);
        end

        // cen low: everything holds even if rate changes
        held_slot = slot;
        rate = 6'd63;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("hold_slot", 32'(slot), 32'(held_slot));
        checkStep("hold", 1'b0, 3'd0);

        // rate_hi 1, rl0: step only at eg_cnt[11:0]==0 with eg_cnt[12] set
        for (int i = 0; i < 32768; i++) begin
            c = 15'(i);
            applyStimulus(6'd4, c);
            want = (c[11:0] == 12'd0) && c[12];
            checkStep("sweep_r4", want, {2'b00, want});
        end
        checkSlot("after_sweep");

        // rate_hi 13 rl0
        applyStimulus(6'd52, 15'd1);  checkStep("r52_c1", 1'b1, 3'd2);
        applyStimulus(6'd52, 15'd2);  checkStep("r52_c2", 1'b1, 3'd1);
        // rate_hi 13 rl1 (BA)
        applyStimulus(6'd53, 15'd0);  checkStep("r53_c0", 1'b1, 3'd1);
        applyStimulus(6'd53, 15'd4);  checkStep("r53_c4", 1'b1, 3'd2);
        // rate_hi 14 rl0
        applyStimulus(6'd56, 15'd3);  checkStep("r56_c3", 1'b1, 3'd4);
        applyStimulus(6'd56, 15'd0);  checkStep("r56_c0", 1'b1, 3'd2);
        // rate_hi 12 rl0: shift by 1
        applyStimulus(6'd48, 15'd2);  checkStep("r48_c2", 1'b1, 3'd1);
        applyStimulus(6'd48, 15'd3);  checkStep("r48_c3", 1'b0, 3'd0);
        applyStimulus(6'd48, 15'd4);  checkStep("r48_c4", 1'b0, 3'd0);
        // rate_hi 1 rl3 (FE)
        applyStimulus(6'd7, 15'h0000); checkStep("r7_c0", 1'b0, 3'd0);
        applyStimulus(6'd7, 15'h2000); checkStep("r7_c2000", 1'b1, 3'd1);
        // rate_hi 1 rl2 (EE): idx 4 -> bit4 of EE is 0, idx 5 -> 1
        applyStimulus(6'd6, 15'h4000); checkStep("r6_c4000", 1'b0, 3'd0);
        applyStimulus(6'd6, 15'h5000); checkStep("r6_c5000", 1'b1, 3'd1);
        checkSlot("after_directed");

        // Fastest and slowest rates for a full frame
        for (int n = 0; n < 18; n++) begin
            applyStimulus(6'd63, 15'(n * 97));
            checkStep("r63", 1'b1, 3'd4);
        end
        for (int n = 0; n < 18; n++) begin
            applyStimulus(6'd3, 15'd0);
            checkStep("r3", 1'b0, 3'd0);
        end
        checkSlot("after_frames");

        // Mid-frame reset at slot 9
        for (int n = 0; n < 18 && exp_slot != 9; n++) begin
            applyStimulus(6'd63, 15'd0);
        end
        checkOutput("pre_rst_slot", 32'(slot), 32'd9);
        checkOutput("pre_rst_step", 32'(step), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("mid_rst_slot", 32'(slot), 32'd0);
        checkOutput("mid_rst_zero", 32'(zero), 32'd0);
        checkOutput("mid_rst_step", 32'(step), 32'd0);
        checkOutput("mid_rst_inc", 32'(inc), 32'd0);
        checkOutput("mid_rst_slot_q", 32'(slot_q), 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        exp_slot = 0;
        exp_prev = 0;
        applyStimulus(6'd63, 15'd0);
        checkOutput("post_rst_slot", 32'(slot), 32'd1);
        checkOutput("post_rst_slot_q", 32'(slot_q), 32'd0);
        checkStep("post_rst", 1'b1, 3'd4);

`ifdef JTOPL_EG_TEST_EN
        // Test register forces maximum step regardless of rate
        test = 1'b1;
        for (int n = 0; n < 18; n++) begin
            applyStimulus(6'd0, 15'd5);
            checkStep("test_force", 1'b1, 3'd4);
        end
        test = 1'b0;
        applyStimulus(6'd0, 15'd5);
        checkStep("test_off", 1'b0, 3'd0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
